// File: rtl/qdiv_arbiter_if.sv
// qdiv_arbiter_if
//   Bundles the requester, response and divider-side signals of the
//   qdiv_arbiter into one interface.
//   slave  : arbiter view (takes requests, drives responses and divider operands)
//   master : environment view (requesters, response consumer, divider)
//   Ports (slave view):
//     in  req_valid[NREQ], req_dividend/req_divisor[NREQ*N], rsp_ready,
//         div_quotient[N], div_complete
//     out req_ready[NREQ], rsp_valid, rsp_id, rsp_quotient[N], rsp_dz,
//         rsp_timeout, div_start, div_dividend[N], div_divisor[N]
interface qdiv_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_dividend;
  logic [NREQ*N-1:0] req_divisor;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_quotient;
  logic              rsp_dz;
  logic              rsp_timeout;
  logic              div_start;
  logic [N-1:0]      div_dividend;
  logic [N-1:0]      div_divisor;
  logic [N-1:0]      div_quotient;
  logic              div_complete;

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
           div_quotient, div_complete,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_dz, rsp_timeout,
           div_start, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
           div_quotient, div_complete,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_dz, rsp_timeout,
           div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/qdiv_arbiter.sv
// qdiv_arbiter
//   Round-robin arbiter/sequencer sharing one serial sign-magnitude
//   fixed-point divider among NREQ requesters. One request is in flight at a
//   time; zero divisors are answered directly and a hung divider is aborted
//   after TIMEOUT cycles.
//   Ports:
//     clk : clock, all logic on posedge
//     rst : synchronous active-high reset
//     bus : qdiv_arbiter_if.slave (request, response and divider signals)
module qdiv_arbiter #(
  parameter int N       = 32,
  parameter int Q       = 15,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  qdiv_arbiter_if.slave bus
);
  localparam int IDW  = $clog2(NREQ);
  // The guard must outlast a normal division, so it never drops below N+Q.
  localparam int TLIM = (TIMEOUT > N + Q - 1) ? TIMEOUT : N + Q;
  localparam int TW   = $clog2(TLIM + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_BUSY, S_RESP} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_gnt;
  logic [N-1:0]   r_dvd;
  logic [N-1:0]   r_dvs;
  logic [N-1:0]   r_quot;
  logic           r_dz;
  logic           r_to;
  logic [TW-1:0]  r_timer;

  logic [N-1:0]   w_dvd_arr [NREQ];
  logic [N-1:0]   w_dvs_arr [NREQ];
  logic [IDW-1:0] w_pick;
  logic           w_found;
  logic           w_accept;
  logic           w_dvs_zero;
  logic           w_dz_sign;
  logic [TW-1:0]  w_timer_inc;
  logic           w_timeout;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_dvd_arr[gi] = bus.req_dividend[gi*N +: N];
      assign w_dvs_arr[gi] = bus.req_divisor[gi*N +: N];
    end
  endgenerate

  // First valid requester at or after r_ptr, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = IDW'(idx);
      end
    end
  end

  // A grant also requires the divider to be idle, so a division left running
  // across a reset can never have its quotient attributed to a new request.
  assign w_accept    = (r_state == S_IDLE) && w_found && bus.div_complete && !rst;
  assign w_dvs_zero  = (w_dvs_arr[w_pick][N-2:0] == '0);
  assign w_dz_sign   = w_dvd_arr[w_pick][N-1] ^ w_dvs_arr[w_pick][N-1];
  assign w_timer_inc = r_timer + 1'b1;
  assign w_timeout   = (w_timer_inc >= TW'(TLIM));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_dvs_zero ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_next = S_ARM;
      // complete=1 here is the idle level from before start, not a result.
      S_ARM: begin
        if (w_timeout)              w_state_next = S_RESP;
        else if (!bus.div_complete) w_state_next = S_BUSY;
      end
      S_BUSY:  if (bus.div_complete || w_timeout) w_state_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready = '0;
    if (w_accept) bus.req_ready[w_pick] = 1'b1;
    bus.div_start = (r_state == S_ISSUE) && !rst;
    bus.rsp_valid = (r_state == S_RESP) && !rst;
  end

  // Datapath: operands, response fields, pointer and timer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_quot  <= '0;
      r_dz    <= 1'b0;
      r_to    <= 1'b0;
      r_timer <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_gnt  <= w_pick;
            r_dvd  <= w_dvd_arr[w_pick];
            r_dvs  <= w_dvs_arr[w_pick];
            r_dz   <= w_dvs_zero;
            r_to   <= 1'b0;
            r_quot <= w_dvs_zero ? {w_dz_sign, {(N-1){1'b1}}} : '0;
          end
        end
        S_ISSUE: r_timer <= '0;
        S_ARM: begin
          r_timer <= w_timer_inc;
          if (w_timeout) begin
            r_quot <= '0;
            r_to   <= 1'b1;
          end
        end
        S_BUSY: begin
          r_timer <= w_timer_inc;
          if (bus.div_complete) begin
            r_quot <= bus.div_quotient;
          end else if (w_timeout) begin
            r_quot <= '0;
            r_to   <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) r_ptr <= (r_gnt == IDW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_id       = r_gnt;
  assign bus.rsp_quotient = r_quot;
  assign bus.rsp_dz       = r_dz;
  assign bus.rsp_timeout  = r_to;
  assign bus.div_dividend = r_dvd;
  assign bus.div_divisor  = r_dvs;
endmodule
